// File: rtl/id_operand_unit_pkg.sv
// Shared decode-stage constants: default datapath widths and IF->ID payload layout.
package id_operand_unit_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int AW_DEF     = 5;
  localparam int BUS_WD_DEF = 64;

  // IF->ID payload is {inst, pc}; the payload is carried opaquely through ID.
  localparam int BUS_PC_LSB   = 0;
  localparam int BUS_INST_LSB = 32;

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard for long-latency producers (mul/div).
// One bit per architectural register; r0 is never marked pending.
module id_scoreboard #(
  parameter int AW   = 5,
  parameter int NSRC = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               set_en,
  input  logic [AW-1:0]      set_addr,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_addr,
  input  logic [NSRC*AW-1:0] lk_addr,
  output logic [NSRC-1:0]    lk_busy
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pend_d[set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Pending vector register; cleared on reset.
  always_ff @(posedge clk) begin
    if (!resetn) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  for (genvar s = 0; s < NSRC; s++) begin : gen_lk
    assign lk_busy[s] = pend_q[lk_addr[s*AW +: AW]];
  end

endmodule

// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: IF->ID pipeline register, priority bypass
// network with load-use and scoreboard hazards, and a saturating stall counter.
module id_operand_unit
  import id_operand_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = AW_DEF,
  parameter int NSRC   = 2,
  parameter int NFWD   = 3,
  parameter int BUS_WD = BUS_WD_DEF,
  parameter int CNT_WD = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [BUS_WD-1:0]    in_bus,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [BUS_WD-1:0]    out_bus,
  input  logic                 flush,
  input  logic [NSRC-1:0]      src_used,
  input  logic [NSRC*AW-1:0]   src_addr,
  output logic [NSRC*AW-1:0]   rf_raddr,
  input  logic [NSRC*XLEN-1:0] rf_rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_blk,
  input  logic [NFWD*AW-1:0]   fwd_dest,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [NSRC*XLEN-1:0] src_value,
  input  logic                 sb_set_req,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_clr,
  input  logic [AW-1:0]        sb_clr_addr,
  output logic [CNT_WD-1:0]    stall_cnt
);

  logic              valid_q, valid_d;
  logic [BUS_WD-1:0] bus_q, bus_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic [NSRC-1:0]   src_haz;
  logic [NSRC-1:0]   sb_busy;
  logic              ready_go;
  logic              sb_set;

  assign rf_raddr = src_addr;

  for (genvar s = 0; s < NSRC; s++) begin : gen_src
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    logic            blk;

    assign addr = src_addr[s*AW +: AW];

    // Walk bypasses oldest-to-youngest so the lowest matching index wins,
    // carrying that source's blocked flag; r0 always reads as zero.
    always_comb begin
      val = rf_rdata[s*XLEN +: XLEN];
      blk = 1'b0;
      for (int f = NFWD - 1; f >= 0; f--) begin
        if (src_used[s] && fwd_valid[f] && (fwd_dest[f*AW +: AW] == addr)) begin
          val = fwd_data[f*XLEN +: XLEN];
          blk = fwd_blk[f];
        end
      end
      if (addr == '0) begin
        val = '0;
        blk = 1'b0;
      end
    end

    assign src_value[s*XLEN +: XLEN] = val;
    assign src_haz[s] = src_used[s] && (addr != '0) && (blk || sb_busy[s]);
  end

  assign ready_go   = ~|src_haz;
  assign in_allowin = !valid_q || (ready_go && out_allowin);
  assign out_valid  = valid_q && ready_go && !flush;
  assign out_bus    = bus_q;
  assign stall_cnt  = cnt_q;
  assign sb_set     = sb_set_req && out_valid && out_allowin && (sb_set_addr != '0);

  id_scoreboard #(
    .AW   (AW),
    .NSRC (NSRC)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .set_en   (sb_set),
    .set_addr (sb_set_addr),
    .clr_en   (sb_clr),
    .clr_addr (sb_clr_addr),
    .lk_addr  (src_addr),
    .lk_busy  (sb_busy)
  );

  // Next-state for the held instruction and the saturating stall counter.
  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_allowin) begin
      valid_d = in_valid;
      if (in_valid) bus_d = in_bus;
    end
    if (valid_q && !ready_go && !flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_WD'(1);
  end

  // Control state: valid flag and stall counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload register; content is irrelevant while valid is low.
  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// Randomized scoreboard bench for id_operand_unit with a behavioural model.
module tb_id_operand_unit;

  localparam int XLEN    = 32;
  localparam int AW      = 5;
  localparam int NSRC    = 2;
  localparam int NFWD    = 3;
  localparam int BUS_WD  = 64;
  localparam int CNT_WD  = 3;
  localparam int CNT_MAX = (1 << CNT_WD) - 1;

  logic                 clk;
  logic                 resetn;
  logic                 in_valid;
  logic                 in_allowin;
  logic [BUS_WD-1:0]    in_bus;
  logic                 out_valid;
  logic                 out_allowin;
  logic [BUS_WD-1:0]    out_bus;
  logic                 flush;
  logic [NSRC-1:0]      src_used;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC*AW-1:0]   rf_raddr;
  logic [NSRC*XLEN-1:0] rf_rdata;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_blk;
  logic [NFWD*AW-1:0]   fwd_dest;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NSRC*XLEN-1:0] src_value;
  logic                 sb_set_req;
  logic [AW-1:0]        sb_set_addr;
  logic                 sb_clr;
  logic [AW-1:0]        sb_clr_addr;
  logic [CNT_WD-1:0]    stall_cnt;

  id_operand_unit #(
    .XLEN(XLEN), .AW(AW), .NSRC(NSRC), .NFWD(NFWD), .BUS_WD(BUS_WD), .CNT_WD(CNT_WD)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_bus(in_bus), .out_valid(out_valid), .out_allowin(out_allowin), .out_bus(out_bus),
    .flush(flush), .src_used(src_used), .src_addr(src_addr), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_blk(fwd_blk), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .src_value(src_value), .sb_set_req(sb_set_req),
    .sb_set_addr(sb_set_addr), .sb_clr(sb_clr), .sb_clr_addr(sb_clr_addr),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              ov;
    logic              ia;
    logic [CNT_WD-1:0] cnt;
    logic [XLEN-1:0]   v0;
    logic [XLEN-1:0]   v1;
    logic [NSRC*AW-1:0] raddr;
  } cyc_t;

  cyc_t              cyc_q[$];
  logic [BUS_WD-1:0] xfer_q[$];
  cyc_t              mon_e;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: held instruction, pending registers, stall count.
  bit                m_valid = 0;
  logic [BUS_WD-1:0] m_bus = '0;
  bit                m_pend [1 << AW];
  int                m_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: operands and hazards from the architectural rules, then state update.
  task automatic model_eval();
    logic [XLEN-1:0] v [NSRC];
    logic [AW-1:0]   a;
    bit found, b, haz, rg, ia, ov;
    cyc_t e;
    haz = 0;
    for (int s = 0; s < NSRC; s++) begin
      a = src_addr[s*AW +: AW];
      v[s] = rf_rdata[s*XLEN +: XLEN];
      found = 0;
      b = 0;
      if (a == 0) v[s] = '0;
      else if (src_used[s]) begin
        for (int f = 0; f < NFWD; f++) begin
          if (!found && fwd_valid[f] && fwd_dest[f*AW +: AW] == a) begin
            found = 1;
            v[s] = fwd_data[f*XLEN +: XLEN];
            b = fwd_blk[f];
          end
        end
      end
      if (src_used[s] && a != 0 && (b || m_pend[a])) haz = 1;
    end
    rg = !haz;
    ia = !m_valid || (rg && out_allowin);
    ov = m_valid && rg && !flush;
    e.ov = ov; e.ia = ia; e.cnt = CNT_WD'(m_cnt);
    e.v0 = v[0]; e.v1 = v[1]; e.raddr = src_addr;
    cyc_q.push_back(e);
    if (ov && out_allowin) xfer_q.push_back(m_bus);
    if (!resetn) begin
      m_valid = 0;
      m_cnt = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (m_valid && !rg && !flush && m_cnt < CNT_MAX) m_cnt++;
      if (sb_clr) m_pend[sb_clr_addr] = 0;
      if (ov && out_allowin && sb_set_req && sb_set_addr != 0) m_pend[sb_set_addr] = 1;
      if (flush) m_valid = 0;
      else if (ia) begin
        m_valid = in_valid;
        if (in_valid) m_bus = in_bus;
      end
    end
  endtask

  // Monitor: per-cycle outputs and, on each EX handshake, the payload.
  always @(negedge clk) begin
    #2;
    if (cyc_q.size() != 0) begin
      mon_e = cyc_q.pop_front();
      chk("out_valid",  64'(out_valid),  64'(mon_e.ov));
      chk("in_allowin", 64'(in_allowin), 64'(mon_e.ia));
      chk("stall_cnt",  64'(stall_cnt),  64'(mon_e.cnt));
      chk("src_value0", 64'(src_value[0 +: XLEN]),    64'(mon_e.v0));
      chk("src_value1", 64'(src_value[XLEN +: XLEN]), 64'(mon_e.v1));
      chk("rf_raddr",   64'(rf_raddr),   64'(mon_e.raddr));
      if (out_valid && out_allowin) begin
        if (xfer_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL transfer actual=handshake required=no_handshake at %0t", $time);
        end else begin
          chk("out_bus", out_bus, xfer_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    #1;
    model_eval();
    @(negedge clk);
  endtask

  task automatic idle();
    resetn = 1; in_valid = 0; in_bus = '0; out_allowin = 1; flush = 0;
    src_used = '0; src_addr = '0; rf_rdata = {$urandom, $urandom};
    fwd_valid = '0; fwd_blk = '0; fwd_dest = '0; fwd_data = '0;
    sb_set_req = 0; sb_set_addr = '0; sb_clr = 0; sb_clr_addr = '0;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1;
    in_bus = {inst, pc};
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] a);
    src_used[s] = 1'b1;
    src_addr[s*AW +: AW] = a;
  endtask

  task automatic set_fwd(input int f, input logic [AW-1:0] d, input logic [XLEN-1:0] data, input bit blk);
    fwd_valid[f] = 1'b1;
    fwd_blk[f] = blk;
    fwd_dest[f*AW +: AW] = d;
    fwd_data[f*XLEN +: XLEN] = data;
  endtask

  task automatic rand_inputs();
    resetn      = ($urandom_range(63) != 0);
    in_valid    = ($urandom_range(3) != 0);
    in_bus      = {$urandom, $urandom};
    out_allowin = ($urandom_range(3) != 0);
    flush       = ($urandom_range(15) == 0);
    src_used    = NSRC'($urandom);
    for (int s = 0; s < NSRC; s++) src_addr[s*AW +: AW] = AW'($urandom_range(7));
    rf_rdata    = {$urandom, $urandom};
    fwd_valid   = NFWD'($urandom);
    for (int f = 0; f < NFWD; f++) begin
      fwd_blk[f] = ($urandom_range(3) == 0);
      fwd_dest[f*AW +: AW] = AW'($urandom_range(7));
      fwd_data[f*XLEN +: XLEN] = $urandom;
    end
    sb_set_req  = ($urandom_range(3) == 0);
    sb_set_addr = AW'($urandom_range(7));
    sb_clr      = ($urandom_range(2) == 0);
    sb_clr_addr = AW'($urandom_range(7));
  endtask

  initial begin
    foreach (m_pend[i]) m_pend[i] = 0;
    idle();
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;

    // Reset state, then a hazard-free instruction.
    step();
    idle(); fetch(32'h0280_0421, 32'h1c00_0000); set_src(0, 1); set_src(1, 2); step();
    in_valid = 0; step();

    // Forward priority and r0.
    idle(); fetch(32'h0010_1485, 32'h1c00_0004); step();
    idle(); out_allowin = 0; set_src(0, 5);
    set_fwd(0, 5, 32'h0000_AAAA, 0); set_fwd(2, 5, 32'h0000_BBBB, 0); step();
    fwd_valid[0] = 0; step();
    set_src(0, 0); set_fwd(0, 0, 32'h0000_1234, 0); step();
    out_allowin = 1; step();

    // Load-use stall for two cycles.
    idle(); fetch(32'h0010_1c86, 32'h1c00_0008); step();
    idle(); set_src(1, 7); set_fwd(0, 7, 32'h0000_0077, 1); step(); step();
    fwd_blk[0] = 0; step();
    idle(); step();

    // Scoreboard set, stall, clear with writeback bypass.
    idle(); fetch(32'h001c_2529, 32'h1c00_000c); step();
    idle(); sb_set_req = 1; sb_set_addr = 9; fetch(32'h0010_250a, 32'h1c00_0010); step();
    idle(); set_src(0, 9); step(); step();
    sb_clr = 1; sb_clr_addr = 9; set_fwd(2, 9, 32'h0000_0055, 0); step();
    sb_clr = 0; step();

    // Same-cycle set and clear of r9: set wins.
    idle(); fetch(32'h001c_2529, 32'h1c00_0014); step();
    idle(); sb_set_req = 1; sb_set_addr = 9; sb_clr = 1; sb_clr_addr = 9;
    fetch(32'h0010_250b, 32'h1c00_0018); step();
    idle(); set_src(0, 9); step(); step();

    // Flush of the stalled instruction while IF offers a new one.
    flush = 1; fetch(32'h0010_250c, 32'h1c00_001c); step();
    idle(); set_src(0, 9); step();
    sb_clr = 1; sb_clr_addr = 9; step();
    idle(); step();

    // Reset mid-stall.
    idle(); fetch(32'h001c_2d8c, 32'h1c00_0020); step();
    idle(); sb_set_req = 1; sb_set_addr = 12; fetch(32'h0010_318d, 32'h1c00_0024); step();
    idle(); set_src(1, 12); step(); step();
    resetn = 0; step();
    idle(); set_src(1, 12); step();
    fetch(32'h0010_318e, 32'h1c00_0028); step();
    in_valid = 0; step();

    // Counter saturation over ten stall cycles.
    idle(); fetch(32'h0010_0c63, 32'h1c00_002c); step();
    idle(); set_src(0, 3); set_fwd(1, 3, 32'h0, 1); repeat (10) step();
    idle(); step(); step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      step();
    end
    idle(); step(); step();

    #3;
    chk("xfer_queue_left", 64'(xfer_q.size()), 64'd0);
    chk("cycle_queue_left", 64'(cyc_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
